// File: rtl/mem_copy_loader_pkg.sv
// mem_copy_loader_pkg
// Shared definitions for the ROM-to-RAM block copier: the controller state
// encoding and the largest ROM read latency the tag pipeline is built for.
package mem_copy_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } copy_state_t;

    localparam int ROM_LAT_MAX = 3;

endpackage

// File: rtl/mem_copy_loader_tag_pipe.sv
// lat_tag_pipe
// Depth-N shift register of {valid, addr} tags that tracks ROM reads in flight
// so each returning data word can be paired with its RAM destination address.
// At DEPTH 0 the tag passes straight through combinationally.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset (clears valids)
//   flush             synchronous clear of every valid bit, wins over in_valid
//   in_valid, in_addr tag pushed this cycle
//   out_valid,out_addr tag emerging this cycle (DEPTH cycles after the push)
//   pending           a valid tag sits upstream of the output stage, i.e. the
//                     pipeline will still be non-empty next cycle
module lat_tag_pipe #(
    parameter int DEPTH  = 1,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic              pending
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign out_valid = in_valid;
            assign out_addr  = in_addr;
            assign pending   = 1'b0;
        end else begin : g_shift
            logic [DEPTH-1:0]  vld;
            logic [ADDR_W-1:0] addr [DEPTH];

            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    vld <= '0;
                end else begin
                    vld[0] <= in_valid;
                    for (int k = 1; k < DEPTH; k++) begin
                        vld[k] <= vld[k-1];
                    end
                end
            end

            // Addresses need no reset: they are only looked at when the
            // matching valid bit is set.
            always_ff @(posedge clk) begin
                addr[0] <= in_addr;
                for (int k = 1; k < DEPTH; k++) begin
                    addr[k] <= addr[k-1];
                end
            end

            assign out_valid = vld[DEPTH-1];
            assign out_addr  = addr[DEPTH-1];

            if (DEPTH > 1) begin : g_pend
                assign pending = |vld[DEPTH-2:0];
            end else begin : g_nopend
                assign pending = 1'b0;
            end
        end
    endgenerate

endmodule

// File: rtl/mem_copy_loader.sv
// mem_copy_loader
// ROM-to-RAM block copier used to initialise frame/pattern RAMs. A start pulse
// in IDLE latches {src_base, dst_base, len}; after a range check the block
// issues one ROM read per cycle and writes each returning word to RAM when its
// tag leaves the latency pipeline. While idle, the host read address is passed
// through to the RAM read port.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 copy request, only sampled in IDLE
//   src_base, dst_base    first ROM / RAM address of the copy
//   len                   number of words (0 .. 2^ADDR_W)
//   abort                 cancel the copy in progress
//   busy, done, err       status: copy active, success pulse, range-reject pulse
//   words_done            RAM writes issued in the current or last copy
//   rom_rd_en, rom_addr   ROM read port
//   rom_data              ROM data, valid ROM_LAT cycles after rom_rd_en
//   ram_we, ram_wr_addr,
//   ram_wr_data           RAM write port
//   host_rd_addr          host read address
//   ram_rd_addr,
//   host_rd_ok            RAM read address and flag that it follows the host
//
// ROM_LAT is meant to stay within 0..ROM_LAT_MAX; larger values are clamped.
module mem_copy_loader
    import mem_copy_loader_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = ADDR_W + 1,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [LEN_W-1:0]  words_done,
    output logic              rom_rd_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    input  logic [ADDR_W-1:0] host_rd_addr,
    output logic [ADDR_W-1:0] ram_rd_addr,
    output logic              host_rd_ok
);

    localparam int SUM_W      = LEN_W + 1;
    localparam int PIPE_DEPTH = (ROM_LAT > ROM_LAT_MAX) ? ROM_LAT_MAX : ROM_LAT;
    localparam logic [SUM_W-1:0] MEM_WORDS = SUM_W'(1) << ADDR_W;

    copy_state_t       state, state_next;
    logic [ADDR_W-1:0] src_r, dst_r;
    logic [LEN_W-1:0]  len_r, issue_cnt;
    logic [ADDR_W-1:0] issue_off;
    logic              err_r;
    logic              range_bad, start_ok, abort_now, last_issue;
    logic              tag_valid, tag_pending;
    logic [ADDR_W-1:0] tag_addr;

    // The sums are formed one bit wider than len so that a copy ending exactly
    // at the top of memory (base+len == 2^ADDR_W) is distinguishable from one
    // that runs past it.
    assign range_bad = (({{(SUM_W-ADDR_W){1'b0}}, src_base} + {1'b0, len}) > MEM_WORDS) ||
                       (({{(SUM_W-ADDR_W){1'b0}}, dst_base} + {1'b0, len}) > MEM_WORDS);
    assign start_ok   = (state == ST_IDLE) && start && !range_bad;
    assign abort_now  = abort && (state != ST_IDLE);
    assign issue_off  = issue_cnt[ADDR_W-1:0];
    assign last_issue = (issue_cnt == len_r - LEN_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // With no ROM latency the last write coincides with the last issue, so
    // ISSUE goes straight to DONE. Otherwise DRAIN holds until only the tag at
    // the pipeline output is left, which is written in that same cycle.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        rom_rd_en  = 1'b0;
        host_rd_ok = 1'b0;
        case (state)
            ST_IDLE: begin
                host_rd_ok = 1'b1;
                if (start && !range_bad) begin
                    state_next = (len == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                busy      = 1'b1;
                rom_rd_en = 1'b1;
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (last_issue) begin
                    state_next = (PIPE_DEPTH == 0) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (!tag_pending) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Request fields, issue index, write counter and the range-reject pulse.
    // words_done is cleared only when a copy is accepted, so after an abort or
    // a rejected request it still shows the last copy's count.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_r      <= '0;
            dst_r      <= '0;
            len_r      <= '0;
            issue_cnt  <= '0;
            words_done <= '0;
            err_r      <= 1'b0;
        end else begin
            err_r <= (state == ST_IDLE) && start && range_bad;
            if ((state == ST_IDLE) && start) begin
                src_r <= src_base;
                dst_r <= dst_base;
                len_r <= len;
            end
            if (start_ok) begin
                issue_cnt  <= '0;
                words_done <= '0;
            end else begin
                if (rom_rd_en) begin
                    issue_cnt <= issue_cnt + LEN_W'(1);
                end
                if (ram_we) begin
                    words_done <= words_done + LEN_W'(1);
                end
            end
        end
    end

    lat_tag_pipe #(
        .DEPTH  (PIPE_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_tag_pipe (
        .clk       (clk),
        .reset     (reset),
        .flush     (abort_now),
        .in_valid  (rom_rd_en),
        .in_addr   (dst_r + issue_off),
        .out_valid (tag_valid),
        .out_addr  (tag_addr),
        .pending   (tag_pending)
    );

    assign err         = err_r;
    assign rom_addr    = rom_rd_en ? (src_r + issue_off) : '0;
    assign ram_we      = tag_valid;
    assign ram_wr_addr = tag_valid ? tag_addr : '0;
    assign ram_wr_data = tag_valid ? rom_data : '0;
    assign ram_rd_addr = host_rd_ok ? host_rd_addr : '0;

endmodule

// File: tb/tb_mem_copy_loader.sv
// tb_mem_copy_loader
// Runs three copies of mem_copy_loader side by side (ROM_LAT 0, 1 and 3) on
// the same request stream. Each copy request is a table record; expected
// per-cycle outputs come from a closed-form timeline of the copy (issue
// window, write window, done cycle) rather than from any state machine.
module tb_mem_copy_loader;

    typedef struct {
        logic [7:0] src;
        logic [7:0] dst;
        logic [8:0] len;
        int         abort_at;
        int         second_at;
        int         reset_at;
        bit         has_exp;
        logic [8:0] exp_words;
    } vec_t;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        err;
        logic [8:0]  words;
        logic        rd_en;
        logic [7:0]  rom_addr;
        logic        we;
        logic [7:0]  wr_addr;
        logic [31:0] wr_data;
        logic [7:0]  rd_addr;
        logic        host_ok;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  src_base;
    logic [7:0]  dst_base;
    logic [8:0]  len;
    logic        abort;
    logic [7:0]  host_rd_addr;

    logic        busy_o      [3];
    logic        done_o      [3];
    logic        err_o       [3];
    logic [8:0]  words_o     [3];
    logic        rom_rd_en_o [3];
    logic [7:0]  rom_addr_o  [3];
    logic [31:0] rom_data_i  [3];
    logic        ram_we_o    [3];
    logic [7:0]  wr_addr_o   [3];
    logic [31:0] wr_data_o   [3];
    logic [7:0]  rd_addr_o   [3];
    logic        host_ok_o   [3];

    logic [31:0] rom [256];

    int          compared   = 0;
    int          mismatched = 0;
    int          cur_cycle  = 0;
    logic [8:0]  prev_words [3];

    always #5 clk = ~clk;

    function automatic int lat_of(input int g);
        return (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
        logic [31:0] rd_now;
        assign rd_now = rom_rd_en_o[g] ? rom[rom_addr_o[g]] : 32'hDEADBEEF;

        if (LAT == 0) begin : g_comb
            assign rom_data_i[g] = rd_now;
        end else begin : g_dly
            logic [31:0] dly [LAT];
            always @(posedge clk) begin
                dly[0] <= rd_now;
                for (int k = 1; k < LAT; k++) dly[k] <= dly[k-1];
            end
            assign rom_data_i[g] = dly[LAT-1];
        end

        mem_copy_loader #(
            .ADDR_W  (8),
            .DATA_W  (32),
            .LEN_W   (9),
            .ROM_LAT (LAT)
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .start        (start),
            .src_base     (src_base),
            .dst_base     (dst_base),
            .len          (len),
            .abort        (abort),
            .busy         (busy_o[g]),
            .done         (done_o[g]),
            .err          (err_o[g]),
            .words_done   (words_o[g]),
            .rom_rd_en    (rom_rd_en_o[g]),
            .rom_addr     (rom_addr_o[g]),
            .rom_data     (rom_data_i[g]),
            .ram_we       (ram_we_o[g]),
            .ram_wr_addr  (wr_addr_o[g]),
            .ram_wr_data  (wr_data_o[g]),
            .host_rd_addr (host_rd_addr),
            .ram_rd_addr  (rd_addr_o[g]),
            .host_rd_ok   (host_ok_o[g])
        );
    end

    // Expected outputs at cycle c of a request (start driven in cycle 0).
    // Legal copy: reads in cycles 1..len, writes in cycles 1+lat..len+lat,
    // done at len+lat+1 (cycle 1 for len 0); an abort in cycle A keeps the
    // activity of cycle A and nothing after it.
    function automatic exp_t model(input vec_t v, input int lat, input int c,
                                   input logic [8:0] pw, input logic [7:0] host);
        exp_t e;
        bit   legal, aborted;
        int   end_c, last_c, hi, n, idx;
        e = '0;
        if (v.reset_at >= 0 && c > v.reset_at) begin
            e.host_ok = 1'b1;
            e.rd_addr = host;
            return e;
        end
        e.words = pw;
        legal   = (int'(v.src) + int'(v.len) <= 256) && (int'(v.dst) + int'(v.len) <= 256);
        end_c   = (v.len == 0) ? 1 : int'(v.len) + lat + 1;
        aborted = legal && v.abort_at >= 1 && v.abort_at < end_c;
        last_c  = aborted ? v.abort_at : end_c;
        if (c == 0 || !legal) begin
            e.err     = !legal && (c == 1);
            e.host_ok = 1'b1;
            e.rd_addr = host;
            return e;
        end
        e.busy  = (c <= last_c);
        e.done  = !aborted && (c == end_c);
        e.rd_en = (c <= int'(v.len)) && (c <= last_c);
        if (e.rd_en) e.rom_addr = v.src + 8'(c - 1);
        e.we = (c >= 1 + lat) && (c <= int'(v.len) + lat) && (c <= last_c);
        if (e.we) begin
            idx       = c - 1 - lat;
            e.wr_addr = v.dst + 8'(idx);
            e.wr_data = rom[v.src + 8'(idx)];
        end
        hi = c - 1;
        if (hi > int'(v.len) + lat) hi = int'(v.len) + lat;
        if (hi > last_c) hi = last_c;
        n = hi - (1 + lat) + 1;
        if (n < 0) n = 0;
        e.words   = 9'(n);
        e.host_ok = !e.busy;
        e.rd_addr = e.busy ? 8'd0 : host;
        return e;
    endfunction

    task automatic check(input string name, input int g, input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s lat%0d cycle %0d: got %0h, expected %0h",
                     name, lat_of(g), cur_cycle, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v, input int c);
        reset        = (c == v.reset_at);
        abort        = (c == v.abort_at);
        start        = (c == 0) || (c == v.second_at);
        host_rd_addr = 8'($urandom);
        if (c == 0) begin
            src_base = v.src;
            dst_base = v.dst;
            len      = v.len;
        end else begin
            src_base = 8'($urandom);
            dst_base = 8'($urandom);
            len      = 9'($urandom);
        end
    endtask

    task automatic check_output(input vec_t v, input int c, input bit last);
        exp_t e;
        for (int g = 0; g < 3; g++) begin
            e = model(v, lat_of(g), c, prev_words[g], host_rd_addr);
            check("busy",        g, 32'(busy_o[g]),      32'(e.busy));
            check("done",        g, 32'(done_o[g]),      32'(e.done));
            check("err",         g, 32'(err_o[g]),       32'(e.err));
            check("words_done",  g, 32'(words_o[g]),     32'(e.words));
            check("rom_rd_en",   g, 32'(rom_rd_en_o[g]), 32'(e.rd_en));
            check("rom_addr",    g, 32'(rom_addr_o[g]),  32'(e.rom_addr));
            check("ram_we",      g, 32'(ram_we_o[g]),    32'(e.we));
            check("ram_wr_addr", g, 32'(wr_addr_o[g]),   32'(e.wr_addr));
            check("ram_wr_data", g, wr_data_o[g],        e.wr_data);
            check("ram_rd_addr", g, 32'(rd_addr_o[g]),   32'(e.rd_addr));
            check("host_rd_ok",  g, 32'(host_ok_o[g]),   32'(e.host_ok));
            if (last) prev_words[g] = e.words;
        end
    endtask

    task automatic run_vector(input vec_t v);
        int budget;
        budget = int'(v.len) + 6;
        for (int c = 0; c <= budget; c++) begin
            @(posedge clk);
            #1;
            cur_cycle = c;
            apply_stimulus(v, c);
            @(negedge clk);
            check_output(v, c, c == budget);
        end
        if (v.has_exp) check("table_words", 1, 32'(words_o[1]), 32'(v.exp_words));
    endtask

    function automatic vec_t mk(input int s, input int d, input int l, input int a,
                                input int sec, input int r, input int w);
        vec_t v;
        v.src       = 8'(s);
        v.dst       = 8'(d);
        v.len       = 9'(l);
        v.abort_at  = a;
        v.second_at = sec;
        v.reset_at  = r;
        v.has_exp   = 1'b1;
        v.exp_words = 9'(w);
        return v;
    endfunction

    vec_t table_v [$];

    initial begin
        vec_t v;
        int   s;
        for (int i = 0; i < 256; i++) rom[i] = 32'(i + 100) + 32'(i) * 32'h0101_0000;
        for (int g = 0; g < 3; g++) prev_words[g] = '0;

        // src, dst, len, abort_at, second_start_at, reset_at, words (lat 1)
        table_v.push_back(mk(  0,  16,   7, -1, -1, -1,   7));
        table_v.push_back(mk(  0,  32,   4, -1, -1, -1,   4));
        table_v.push_back(mk(250,   0,   6, -1, -1, -1,   6));
        table_v.push_back(mk(251,   0,   6, -1, -1, -1,   6));
        table_v.push_back(mk( 10,  10,   0, -1, -1, -1,   0));
        table_v.push_back(mk(  0, 200,  57, -1, -1, -1,   0));
        table_v.push_back(mk(  5, 100,  10,  4, -1, -1,   3));
        table_v.push_back(mk( 20,  60,   5, -1, -1, -1,   5));
        table_v.push_back(mk( 40, 120,   6, -1,  3, -1,   6));
        table_v.push_back(mk(  0, 250,   6, -1, -1, -1,   6));
        table_v.push_back(mk(  0,   0, 300, -1, -1, -1,   6));
        table_v.push_back(mk( 33,  77,   8,  0, -1, -1,   8));
        table_v.push_back(mk(  0,  16,   7, -1, -1,  3,   0));
        table_v.push_back(mk(  0,   0, 256, -1, -1, -1, 256));
        table_v.push_back(mk(  1,   2,   3, -1, -1, -1,   3));

        reset        = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        src_base     = '0;
        dst_base     = '0;
        len          = '0;
        host_rd_addr = 8'd5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check("rst_busy",        g, 32'(busy_o[g]),      32'd0);
            check("rst_done",        g, 32'(done_o[g]),      32'd0);
            check("rst_err",         g, 32'(err_o[g]),       32'd0);
            check("rst_words",       g, 32'(words_o[g]),     32'd0);
            check("rst_rom_rd_en",   g, 32'(rom_rd_en_o[g]), 32'd0);
            check("rst_rom_addr",    g, 32'(rom_addr_o[g]),  32'd0);
            check("rst_ram_we",      g, 32'(ram_we_o[g]),    32'd0);
            check("rst_ram_wr_addr", g, 32'(wr_addr_o[g]),   32'd0);
            check("rst_ram_wr_data", g, wr_data_o[g],        32'd0);
            check("rst_ram_rd_addr", g, 32'(rd_addr_o[g]),   32'd5);
            check("rst_host_rd_ok",  g, 32'(host_ok_o[g]),   32'd1);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (table_v[i]) run_vector(table_v[i]);

        for (int t = 0; t < 30; t++) begin
            v.len = 9'($urandom_range(0, 24));
            if ($urandom_range(0, 3) == 0) begin
                s = 256 - int'(v.len) + int'($urandom_range(0, 1));
                if (s > 255) s = 255;
                v.src = 8'(s);
            end else begin
                v.src = 8'($urandom);
            end
            v.dst       = 8'($urandom);
            v.abort_at  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(v.len) + 4)) : -1;
            v.second_at = (v.abort_at == -1 && v.len >= 3 && $urandom_range(0, 2) == 0) ? 2 : -1;
            v.reset_at  = -1;
            v.has_exp   = 1'b0;
            v.exp_words = '0;
            run_vector(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_copy_loader.md
Name: mem_copy_loader

Overview:
Parameterised ROM-to-RAM block copier used to initialise frame or pattern RAMs before the VGA pipeline starts. A host requests a copy with a start pulse and three fields: source base, destination base and length. The block then streams one word per cycle from a ROM with configurable read latency into a RAM write port, and reports busy, done and error status. When idle, it passes a host read address through to the RAM read port.

Parameters:
ADDR_W, 8, address width of both ROM and RAM.
DATA_W, 32, word width.
LEN_W, ADDR_W+1, width of the length field; allows a full-memory copy of 2^ADDR_W words.
ROM_LAT, 1, ROM read latency in cycles. Legal range 0..3; 0 means a combinational ROM.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  request pulse; sampled only in IDLE
src_base  in  ADDR_W  first ROM address
dst_base  in  ADDR_W  first RAM address
len  in  LEN_W  number of words to copy
abort  in  1  cancel the copy in progress
busy  out  1  high from the cycle after start is accepted until the block returns to IDLE
done  out  1  one-cycle pulse when a copy completes successfully
err  out  1  one-cycle pulse when a request is rejected for range
words_done  out  LEN_W  count of RAM writes issued in the current or last copy
rom_rd_en  out  1  ROM read strobe
rom_addr  out  ADDR_W  ROM read address
rom_data  in  DATA_W  ROM read data, valid ROM_LAT cycles after rom_rd_en
ram_we  out  1  RAM write enable
ram_wr_addr  out  ADDR_W  RAM write address
ram_wr_data  out  DATA_W  RAM write data
host_rd_addr  in  ADDR_W  host RAM read address
ram_rd_addr  out  ADDR_W  RAM read address
host_rd_ok  out  1  high when ram_rd_addr reflects host_rd_addr

Behaviour:
- Reset values: state IDLE; busy=0, done=0, err=0, words_done=0, rom_rd_en=0, ram_we=0; all address and data outputs 0; in-flight pipeline valids cleared.
- States:
  - IDLE: on start, latch src_base, dst_base and len, then do the range check.
    - src_base+len > 2^ADDR_W or dst_base+len > 2^ADDR_W: pulse err next cycle, stay IDLE, no writes.
    - len==0: pulse done next cycle, no writes.
    - Otherwise go to ISSUE.
  - ISSUE: each cycle assert rom_rd_en with rom_addr = src_base+i, for i = 0..len-1. Push {valid, dst_base+i} into a ROM_LAT-deep tag pipeline. After the last issue, go to DRAIN.
  - DRAIN: wait until the tag pipeline is empty, then go to DONE.
  - DONE: pulse done for one cycle, then go to IDLE.
- Writes:
  - When a tag emerges from the pipeline, drive ram_we=1, ram_wr_addr=tag, ram_wr_data=rom_data in the same cycle; ram_we is high only on those cycles; words_done increments per write.
  - ROM_LAT=0: writes coincide with issue, and DRAIN lasts 0 cycles.
- Timing: start is sampled at cycle 0.
  - First rom_rd_en at cycle 1.
  - First ram_we at cycle 1+ROM_LAT.
  - Last ram_we at cycle len+ROM_LAT.
  - done at cycle len+ROM_LAT+1.
  - Throughput is one word per cycle, with no bubbles.
- Address arithmetic: performed at ADDR_W bits. Wrap-around is impossible because of the range check; a copy ending exactly at the top of memory (base+len == 2^ADDR_W) is legal.
- Handshake rules:
  - start while busy is ignored; busy stays high for the whole copy.
  - Fields are latched at acceptance, so later input changes have no effect.
- abort (any non-IDLE state):
  - Next cycle: rom_rd_en=0 and ram_we=0, pipeline valids flushed, state IDLE.
  - No done and no err pulse.
  - words_done holds the count of writes completed before abort.
  - abort together with start in IDLE: the start is accepted; the abort is ignored.
- Reset mid-copy: next cycle everything returns to reset values; no further RAM writes.
- Read pass-through:
  - ram_rd_addr = host_rd_addr and host_rd_ok=1 only in IDLE.
  - Otherwise ram_rd_addr=0 and host_rd_ok=0.
  - Combinational from state.

Decomposition:
- Shared package: state encoding constants (IDLE, ISSUE, DRAIN, DONE) and the ROM_LAT legal-range limit.
- Sub-module: lat_tag_pipe, a parameterised depth-N shift register of {valid, addr} with synchronous flush. At depth 0 it is a pass-through.

Test Plan:
- ROM_LAT=1, src=0, dst=16, len=7, ROM[i]=i+100: RAM[16..22]=100..106; first ram_we at cycle 2; done at cycle 9; words_done=7.
- ROM_LAT=0 and ROM_LAT=3, len=4: ram_we on 4 consecutive cycles, starting at cycle 1 and cycle 4 respectively; done at cycles 5 and 8.
- Range boundaries, ADDR_W=8:
  - src=250, len=6: legal; ROM 250..255 is copied and done pulses.
  - src=251, len=6: err pulse at cycle 1; no ram_we ever.
  - len=0: done at cycle 1; no writes.
- Abort:
  - abort at cycle 4 of a len=10 copy: ram_we=0 from cycle 5; done never pulses; words_done=3 (ROM_LAT=1).
  - A subsequent start copies correctly.
- Mid-copy events:
  - reset at cycle 3 mid-copy: all outputs at reset values at cycle 4; no further writes.
  - Second start during busy: ignored; exactly one done pulse.
- Pass-through: host_rd_addr=5 in IDLE gives ram_rd_addr=5 and host_rd_ok=1; during a copy, ram_rd_addr=0 and host_rd_ok=0.
